// File: rtl/qspi_xip_line_arbiter.sv
// qspi_xip_line_arbiter
//   Shares one QSPI XIP cache-line reader between an instruction-fetch port
//   (port 0) and a data-read port (port 1). Round-robin arbitration, one
//   flash transaction in flight, and a single-entry line buffer (tag + valid)
//   that answers repeat hits without touching flash.
//
// Ports
//   clk, rst_n        system clock, async active-low reset
//   req0/addr0/ack0   port 0 request level, byte address, 1-cycle ack pulse
//   req1/addr1/ack1   port 1 request level, byte address, 1-cycle ack pulse
//   line_o            registered line buffer, valid for the acked port in the ack cycle
//   invalidate        drops the buffer valid bit
//   xip_addr/xip_rd   line-aligned address and 1-cycle read strobe to the controller
//   xip_done/xip_line controller completion pulse and line data
//
// state | meaning
// IDLE  | pick a winner, latch its line address, decide hit or miss
// ISSUE | pulse xip_rd for the latched line
// WAIT  | wait for xip_done, then fill the buffer and ack the requester
// RESP  | ack a buffer hit; after a miss fill the ack has already pulsed
module qspi_xip_line_arbiter #(
  parameter int LINE_SIZE = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req0,
  input  logic [23:0]            addr0,
  output logic                   ack0,
  input  logic                   req1,
  input  logic [23:0]            addr1,
  output logic                   ack1,
  output logic [LINE_SIZE*8-1:0] line_o,
  input  logic                   invalidate,
  output logic [23:0]            xip_addr,
  output logic                   xip_rd,
  input  logic                   xip_done,
  input  logic [LINE_SIZE*8-1:0] xip_line
);

  localparam int OFF_W = $clog2(LINE_SIZE);
  localparam int TAG_W = 24 - OFF_W;
  localparam logic [23:0] LINE_MASK = ~24'(LINE_SIZE - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e                 state_q;
  logic                   gnt_q;
  logic                   last_grant_q;
  logic                   valid_q;
  logic                   inval_pend_q;
  logic                   hit_path_q;
  logic [TAG_W-1:0]       tag_q;
  logic [LINE_SIZE*8-1:0] line_q;
  logic [23:0]            xip_addr_q;
  logic                   ack0_q;
  logic                   ack1_q;
  logic                   xip_rd_q;

  // A port whose ack is pulsing has already been served; it must not be
  // picked again in the IDLE cycle that overlaps its ack.
  logic             req0_eff;
  logic             req1_eff;
  logic             win;
  logic [23:0]      win_line_addr;
  logic [TAG_W-1:0] win_la;
  logic [TAG_W-1:0] cur_la;
  logic             hit;

  always_comb begin
    req0_eff      = req0 & ~ack0_q;
    req1_eff      = req1 & ~ack1_q;
    win           = (req0_eff & req1_eff) ? ~last_grant_q : req1_eff;
    win_line_addr = (win ? addr1 : addr0) & LINE_MASK;
    win_la        = win_line_addr[23:OFF_W];
    cur_la        = xip_addr_q[23:OFF_W];
    hit           = valid_q && (tag_q == win_la);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gnt_q        <= 1'b0;
      last_grant_q <= 1'b1;
      valid_q      <= 1'b0;
      inval_pend_q <= 1'b0;
      hit_path_q   <= 1'b0;
      tag_q        <= '0;
      line_q       <= '0;
      xip_addr_q   <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      xip_rd_q     <= 1'b0;
    end else begin
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      xip_rd_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (invalidate) valid_q <= 1'b0;
          if (req0_eff || req1_eff) begin
            gnt_q      <= win;
            xip_addr_q <= win_line_addr;
            hit_path_q <= hit;
            state_q    <= hit ? RESP : ISSUE;
          end
        end
        ISSUE: begin
          if (invalidate) valid_q <= 1'b0;
          xip_rd_q     <= 1'b1;
          inval_pend_q <= 1'b0;
          state_q      <= WAIT;
        end
        WAIT: begin
          if (invalidate) inval_pend_q <= 1'b1;
          if (xip_done) begin
            line_q       <= xip_line;
            tag_q        <= cur_la;
            // An invalidate seen at any point of the wait, including the
            // done cycle itself, beats the fill.
            valid_q      <= ~(invalidate | inval_pend_q);
            // Ack straight out of the fill so it lands the cycle after done.
            ack0_q       <= ~gnt_q;
            ack1_q       <= gnt_q;
            last_grant_q <= gnt_q;
            state_q      <= RESP;
          end
        end
        RESP: begin
          if (invalidate) valid_q <= 1'b0;
          if (hit_path_q) begin
            ack0_q       <= ~gnt_q;
            ack1_q       <= gnt_q;
            last_grant_q <= gnt_q;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign line_o   = line_q;
  assign xip_addr = xip_addr_q;
  assign xip_rd   = xip_rd_q;

endmodule

// File: tb/tb_qspi_xip_line_arbiter.sv
module tb_qspi_xip_line_arbiter;

  localparam int LS = 16;
  localparam int LW = LS * 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, req1;
  logic [23:0]   addr0, addr1;
  logic          ack0, ack1;
  logic [LW-1:0] line_o;
  logic          invalidate;
  logic          inv_tb, inv_ctl;
  logic [23:0]   xip_addr;
  logic          xip_rd;
  logic          xip_done;
  logic [LW-1:0] xip_line;

  assign invalidate = inv_tb | inv_ctl;

  qspi_xip_line_arbiter #(.LINE_SIZE(LS)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .addr0(addr0), .ack0(ack0),
    .req1(req1), .addr1(addr1), .ack1(ack1),
    .line_o(line_o), .invalidate(invalidate),
    .xip_addr(xip_addr), .xip_rd(xip_rd),
    .xip_done(xip_done), .xip_line(xip_line)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  // Flash image: a fixed pattern per line address.
  function automatic logic [LW-1:0] img(input logic [19:0] la);
    logic [LW-1:0] v;
    for (int k = 0; k < LS / 4; k++)
      v[32*k +: 32] = {12'h0, la} * 32'h9E3779B1 + 32'(k) * 32'h01010101;
    return v;
  endfunction

  // Scoreboard
  logic [LW-1:0] exp0_q[$];
  logic [LW-1:0] exp1_q[$];
  int ack_cnt0 = 0;
  int ack_cnt1 = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ack0 && ack1) begin
          chk_cnt++;
          $display("FAIL ack_exclusive: got ack0=1 ack1=1 want at most one");
        end
        if (ack0) begin
          ack_cnt0++;
          if (exp0_q.size() == 0) begin
            chk_cnt++;
            $display("FAIL ack0_unexpected: got ack0=1 want no ack (nothing pending)");
          end else check("ack0_line", line_o, exp0_q.pop_front());
        end
        if (ack1) begin
          ack_cnt1++;
          if (exp1_q.size() == 0) begin
            chk_cnt++;
            $display("FAIL ack1_unexpected: got ack1=1 want no ack (nothing pending)");
          end else check("ack1_line", line_o, exp1_q.pop_front());
        end
      end
    end
  end

  // Controller model
  int          ctl_dly     = 40;
  bit          rnd_dly     = 0;
  bit          inv_on_done = 0;
  int          rd_cnt      = 0;
  logic [23:0] rd_addr_q[$];

  task automatic ctl_model();
    logic [23:0] a;
    int          d;
    bit          aborted;
    forever begin
      @(negedge clk);
      if (rst_n && xip_rd) begin
        a       = xip_addr;
        d       = rnd_dly ? int'($urandom_range(1, 8)) : ctl_dly;
        aborted = 0;
        rd_cnt++;
        rd_addr_q.push_back(a);
        for (int k = 0; k < d; k++) begin
          @(negedge clk);
          if (!rst_n) aborted = 1;
        end
        if (!aborted) begin
          xip_line = img(a[23:4]);
          xip_done = 1'b1;
          if (inv_on_done) inv_ctl = 1'b1;
          @(negedge clk);
          xip_done = 1'b0;
          inv_ctl  = 1'b0;
        end
      end
    end
  endtask

  initial begin
    xip_done = 1'b0;
    xip_line = '0;
    inv_ctl  = 1'b0;
    ctl_model();
  end

  // Requester: raises req, waits for its ack, drops req in the ack cycle.
  task automatic do_req(input bit port, input logic [23:0] a, input int budget, output int lat);
    int other0;
    bit got;
    got    = 0;
    other0 = port ? ack_cnt0 : ack_cnt1;
    if (port) begin exp1_q.push_back(img(a[23:4])); addr1 = a; req1 = 1'b1; end
    else      begin exp0_q.push_back(img(a[23:4])); addr0 = a; req0 = 1'b1; end
    lat = 0;
    while (!got && lat < budget) begin
      @(negedge clk);
      lat++;
      if (port ? ack1 : ack0) got = 1;
    end
    if (port) req1 = 1'b0; else req0 = 1'b0;
    if (!got) begin
      chk_cnt++;
      $display("FAIL req%0d_timeout: got no ack after %0d cycles want ack", port, budget);
    end
    check("fairness", ((port ? ack_cnt0 : ack_cnt1) - other0) <= 1, 1);
  endtask

  task automatic rnd_requester(input bit port, input int stop);
    logic [23:0] a;
    int          lat;
    while (cyc < stop) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      a = 24'h010000 | (24'($urandom_range(0, 5)) << 4) | 24'($urandom_range(0, 15));
      do_req(port, a, 100, lat);
    end
  endtask

  task automatic rnd_inval(input int stop);
    while (cyc < stop) begin
      @(negedge clk);
      if ($urandom_range(0, 49) == 0) begin
        inv_tb = 1'b1;
        @(negedge clk);
        inv_tb = 1'b0;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1);
  end

  int l0, l1, r0, stop;

  initial begin
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0; inv_tb = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack0", ack0, 0);
    check("rst_ack1", ack1, 0);
    check("rst_xip_rd", xip_rd, 0);
    check("rst_xip_addr", xip_addr, 0);
    check("rst_line_o", line_o, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // T1: cold miss with long controller latency
    ctl_dly = 40; r0 = rd_cnt;
    do_req(0, 24'h000104, 100, l0);
    check("t1_lat", l0, 43);
    check("t1_rd_cnt", rd_cnt - r0, 1);
    check("t1_xip_addr", rd_addr_q[$], 24'h000100);
    repeat (2) @(negedge clk);

    // T2: other port hits the same line
    r0 = rd_cnt;
    do_req(1, 24'h00010C, 20, l1);
    check("t2_lat", l1, 2);
    check("t2_rd_cnt", rd_cnt - r0, 0);
    repeat (2) @(negedge clk);

    // T3: port 0 hit first (last_grant=0), then simultaneous misses
    do_req(0, 24'h000100, 20, l0);
    check("t3_hit_lat", l0, 2);
    repeat (2) @(negedge clk);
    ctl_dly = 5; r0 = rd_cnt; rd_addr_q.delete();
    fork
      do_req(0, 24'h002000, 200, l0);
      do_req(1, 24'h003000, 200, l1);
    join
    check("t3_lat1", l1, 8);
    check("t3_lat0", l0, 17);
    check("t3_rd_cnt", rd_cnt - r0, 2);
    check("t3_first_addr", rd_addr_q[0], 24'h003000);
    check("t3_second_addr", rd_addr_q[1], 24'h002000);
    repeat (2) @(negedge clk);

    // T4: invalidate during WAIT, then re-request misses
    fork
      do_req(0, 24'h004000, 200, l0);
      begin
        repeat (6) @(negedge clk);
        inv_tb = 1'b1;
        @(negedge clk);
        inv_tb = 1'b0;
      end
    join
    check("t4_lat", l0, 8);
    repeat (2) @(negedge clk);
    r0 = rd_cnt;
    do_req(0, 24'h004008, 200, l0);
    check("t4_re_lat", l0, 8);
    check("t4_re_rd_cnt", rd_cnt - r0, 1);
    repeat (2) @(negedge clk);

    // T4b: invalidate exactly in the xip_done cycle
    inv_on_done = 1;
    do_req(0, 24'h005000, 200, l0);
    inv_on_done = 0;
    repeat (2) @(negedge clk);
    r0 = rd_cnt;
    do_req(1, 24'h005000, 200, l1);
    check("t4b_re_rd_cnt", rd_cnt - r0, 1);
    check("t4b_re_lat", l1, 8);
    repeat (2) @(negedge clk);

    // T5: reset during WAIT; buffer still holds 0x005000 valid beforehand
    ctl_dly = 30; r0 = rd_cnt;
    addr0 = 24'h006000; req0 = 1'b1;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_ack0", ack0, 0);
    check("t5_ack1", ack1, 0);
    check("t5_xip_rd", xip_rd, 0);
    check("t5_xip_addr", xip_addr, 0);
    check("t5_line_o", line_o, 0);
    req0 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("t5_rd_cnt", rd_cnt - r0, 1);
    ctl_dly = 5; r0 = rd_cnt;
    do_req(0, 24'h005004, 100, l0);
    check("t5_re_lat", l0, 8);
    check("t5_re_rd_cnt", rd_cnt - r0, 1);
    repeat (2) @(negedge clk);

    // T6: random traffic with random controller latency and invalidates
    rnd_dly = 1; rd_addr_q.delete();
    stop = cyc + 2000;
    fork
      rnd_requester(0, stop);
      rnd_requester(1, stop);
      rnd_inval(stop);
    join
    repeat (5) @(negedge clk);
    check("t6_sb0_empty", exp0_q.size(), 0);
    check("t6_sb1_empty", exp1_q.size(), 0);
    check("t6_port0_served", ack_cnt0 > 10, 1);
    check("t6_port1_served", ack_cnt1 > 10, 1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
